// File: rtl/count_term_monitor_pkg.sv
// Shared types and helpers for the terminal-count monitor: error codes,
// monitor states and the violation popcount used by the error counter.
package count_term_monitor_pkg;

   typedef enum logic [1:0] {
      NONE       = 2'd0,
      MISSING_T  = 2'd1,
      SPURIOUS_T = 2'd2,
      BAD_STEP   = 2'd3
   } err_code_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMING = 2'd1,
      ACTIVE = 2'd2
   } mon_state_e;

   // Upper bound on channels the popcount helper accepts.
   localparam int MAX_CHANNELS = 64;
   localparam int POP_W        = 7;

   function automatic logic [POP_W-1:0] popcount(input logic [MAX_CHANNELS-1:0] v);
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < MAX_CHANNELS; i++) begin
         n = n + POP_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/count_term_chk.sv
// One-channel rule checker: terminal-flag consistency and +1 step, with the
// previous-sample register that the step rule needs.
module count_term_chk
   import count_term_monitor_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int TERMINAL   = 2**WIDTH-1,
   parameter int CHECK_STEP = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample,
   input  logic             flush,
   input  logic [WIDTH-1:0] count,
   input  logic             t,
   output logic             viol,
   output err_code_e        code
);

   logic [WIDTH-1:0] prev;
   logic             prev_valid;
   logic             at_term;

   assign at_term = (count == WIDTH'(TERMINAL));

   // Flag rules outrank the step rule when both hold on one sample.
   always_comb begin
      code = NONE;
      if (sample) begin
         if (at_term && !t) begin
            code = MISSING_T;
         end else if (!at_term && t) begin
            code = SPURIOUS_T;
         end else if ((CHECK_STEP != 0) && prev_valid && (count != prev + WIDTH'(1))) begin
            code = BAD_STEP;
         end
      end
   end

   assign viol = (code != NONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev       <= '0;
         prev_valid <= 1'b0;
      end else if (flush) begin
         prev_valid <= 1'b0;
      end else if (sample) begin
         prev       <= count;
         prev_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/count_term_monitor.sv
// Multi-channel run-time monitor for free-running counters with a terminal
// flag: arming FSM, timestamp, saturating error count and first-failure record.
module count_term_monitor
   import count_term_monitor_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int CHANNELS   = 2,
   parameter int TERMINAL   = 2**WIDTH-1,
   parameter int ARM_CYCLES = 2,
   parameter int CHECK_STEP = 1,
   parameter int ERR_CNT_W  = 8,
   parameter int TS_W       = 16,
   localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      clr,
   input  logic [CHANNELS*WIDTH-1:0] count,
   input  logic [CHANNELS-1:0]       t,
   output logic                      armed,
   output logic [CHANNELS-1:0]       err_pulse,
   output logic [CHANNELS-1:0]       err_sticky,
   output logic [ERR_CNT_W-1:0]      err_count,
   output logic                      first_valid,
   output logic [CHAN_W-1:0]         first_chan,
   output logic [1:0]                first_code,
   output logic [TS_W-1:0]           first_ts
);

   localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
   localparam int SUM_W = ERR_CNT_W + POP_W;
   localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

   mon_state_e         state_q, state_d;
   logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
   logic [TS_W-1:0]    ts_q;
   logic               sample;

   logic [CHANNELS-1:0] viol;
   err_code_e           chk_code [CHANNELS];

   logic [CHAN_W-1:0]    hit_chan;
   err_code_e            hit_code;
   logic [CHANNELS-1:0]  sticky_d;
   logic [ERR_CNT_W-1:0] cnt_base, cnt_d;
   logic [SUM_W-1:0]     cnt_sum;
   logic                 first_valid_d;
   logic [CHAN_W-1:0]    first_chan_d;
   logic [1:0]           first_code_d;
   logic [TS_W-1:0]      first_ts_d;

   assign sample = en && (state_q == ACTIVE);

   // ---------------- arming FSM ----------------
   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      arm_cnt_d = arm_cnt_q;
      if (!en) begin
         state_d   = IDLE;
         arm_cnt_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d   = (ARM_CYCLES == 0) ? ACTIVE : ARMING;
               arm_cnt_d = '0;
            end
            ARMING: begin
               if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1)) begin
                  state_d   = ACTIVE;
                  arm_cnt_d = '0;
               end else begin
                  arm_cnt_d = arm_cnt_q + ARM_W'(1);
               end
            end
            ACTIVE:  state_d = ACTIVE;
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------- per-channel checkers ----------------
   for (genvar g = 0; g < CHANNELS; g++) begin : g_chk
      count_term_chk #(
         .WIDTH      (WIDTH),
         .TERMINAL   (TERMINAL),
         .CHECK_STEP (CHECK_STEP)
      ) u_chk (
         .clk    (clk),
         .rst_n  (rst_n),
         .sample (sample),
         .flush  (~en),
         .count  (count[g*WIDTH +: WIDTH]),
         .t      (t[g]),
         .viol   (viol[g]),
         .code   (chk_code[g])
      );
   end

   // Lowest-index violating channel wins: scan downward so it is written last.
   always_comb begin
      hit_chan = '0;
      hit_code = NONE;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (viol[i]) begin
            hit_chan = CHAN_W'(i);
            hit_code = chk_code[i];
         end
      end
   end

   // Clear is applied first, then this cycle's violations land on top of it.
   always_comb begin
      sticky_d      = (clr ? '0 : err_sticky) | viol;
      cnt_base      = clr ? '0 : err_count;
      cnt_sum       = SUM_W'(cnt_base) + SUM_W'(popcount(MAX_CHANNELS'(viol)));
      cnt_d         = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : ERR_CNT_W'(cnt_sum);
      first_valid_d = clr ? 1'b0 : first_valid;
      first_chan_d  = clr ? '0   : first_chan;
      first_code_d  = clr ? 2'd0 : first_code;
      first_ts_d    = clr ? '0   : first_ts;
      if (!first_valid_d && (|viol)) begin
         first_valid_d = 1'b1;
         first_chan_d  = hit_chan;
         first_code_d  = hit_code;
         first_ts_d    = ts_q;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         arm_cnt_q   <= '0;
         ts_q        <= '0;
         armed       <= 1'b0;
         err_pulse   <= '0;
         err_sticky  <= '0;
         err_count   <= '0;
         first_valid <= 1'b0;
         first_chan  <= '0;
         first_code  <= 2'd0;
         first_ts    <= '0;
      end else begin
         state_q     <= state_d;
         arm_cnt_q   <= arm_cnt_d;
         ts_q        <= ts_q + TS_W'(1);
         armed       <= (state_d == ACTIVE);
         err_pulse   <= viol;
         err_sticky  <= sticky_d;
         err_count   <= cnt_d;
         first_valid <= first_valid_d;
         first_chan  <= first_chan_d;
         first_code  <= first_code_d;
         first_ts    <= first_ts_d;
      end
   end

endmodule

// File: tb/tb_count_term_monitor.sv
// Directed bench for count_term_monitor (WIDTH=4, CHANNELS=2, ARM_CYCLES=2):
// hand-computed expectations for arming, each error code, clear and reset.
module tb_count_term_monitor;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        clr;
   logic [7:0]  count;
   logic [1:0]  t;
   logic        armed;
   logic [1:0]  err_pulse;
   logic [1:0]  err_sticky;
   logic [7:0]  err_count;
   logic        first_valid;
   logic [0:0]  first_chan;
   logic [1:0]  first_code;
   logic [15:0] first_ts;

   int vectors;
   int miscompares;

   logic [3:0]  c0, c1;
   logic [15:0] ts_model;
   logic [15:0] edge_ts;
   logic [15:0] saved_ts;
   logic [1:0]  exp_code;

   count_term_monitor #(
      .WIDTH      (4),
      .CHANNELS   (2),
      .ARM_CYCLES (2),
      .CHECK_STEP (1),
      .ERR_CNT_W  (8),
      .TS_W       (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .clr         (clr),
      .count       (count),
      .t           (t),
      .armed       (armed),
      .err_pulse   (err_pulse),
      .err_sticky  (err_sticky),
      .err_count   (err_count),
      .first_valid (first_valid),
      .first_chan  (first_chan),
      .first_code  (first_code),
      .first_ts    (first_ts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Drive both channels with the bench's counts; f0/f1 invert the correct
   // terminal flag. Returns #1 after the edge with counts advanced by one.
   task automatic tick(input logic f0, input logic f1);
      count   = {c1, c0};
      t       = {(c1 == 4'd15) ^ f1, (c0 == 4'd15) ^ f0};
      edge_ts = ts_model;
      @(posedge clk);
      ts_model = ts_model + 16'd1;
      #1;
      c0 = c0 + 4'd1;
      c1 = c1 + 4'd1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " armed"},       32'(armed),       32'd0);
      check({tag, " err_pulse"},   32'(err_pulse),   32'd0);
      check({tag, " err_sticky"},  32'(err_sticky),  32'd0);
      check({tag, " err_count"},   32'(err_count),   32'd0);
      check({tag, " first_valid"}, 32'(first_valid), 32'd0);
      check({tag, " first_chan"},  32'(first_chan),  32'd0);
      check({tag, " first_code"},  32'(first_code),  32'd0);
      check({tag, " first_ts"},    32'(first_ts),    32'd0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n = 1'b0;
      en    = 1'b0;
      clr   = 1'b0;
      count = '0;
      t     = '0;
      c0    = 4'd3;
      c1    = 4'd0;
      ts_model = '0;

      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      ts_model = '0;

      // Clean counting: armed rises after the 3rd enabled edge, no errors.
      en = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick(1'b0, 1'b0);
         check("clean err_pulse", 32'(err_pulse), 32'd0);
         if (k <= 4) check("arming armed", 32'(armed), 32'(k >= 3));
      end
      check("clean err_count",   32'(err_count),   32'd0);
      check("clean err_sticky",  32'(err_sticky),  32'd0);
      check("clean first_valid", 32'(first_valid), 32'd0);

      // Channel 1 misses t at 15 (ch0 at 2, still legal).
      while (c1 != 4'd15) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      saved_ts = edge_ts;
      check("missing err_pulse",   32'(err_pulse),   32'h2);
      check("missing err_sticky",  32'(err_sticky),  32'h2);
      check("missing err_count",   32'(err_count),   32'd1);
      check("missing first_valid", 32'(first_valid), 32'd1);
      check("missing first_chan",  32'(first_chan),  32'd1);
      check("missing first_code",  32'(first_code),  32'd1);
      check("missing first_ts",    32'(first_ts),    32'(saved_ts));
      tick(1'b0, 1'b0);
      check("pulse one cycle", 32'(err_pulse), 32'd0);
      check("sticky holds",    32'(err_sticky), 32'h2);

      // Quiet clear: record wiped, nothing new.
      clr = 1'b1;
      tick(1'b0, 1'b0);
      clr = 1'b0;
      check("clr err_count",   32'(err_count),   32'd0);
      check("clr err_sticky",  32'(err_sticky),  32'd0);
      check("clr first_valid", 32'(first_valid), 32'd0);
      check("clr first_ts",    32'(first_ts),    32'd0);

      // ch0 5 -> 7 (BAD_STEP) and ch1 t=1 at 3 (SPURIOUS_T) on one edge.
      tick(1'b0, 1'b0);
      c0 = 4'd7;
      tick(1'b0, 1'b1);
      saved_ts = edge_ts;
      check("dual err_pulse",  32'(err_pulse),  32'h3);
      check("dual err_count",  32'(err_count),  32'd2);
      check("dual first_chan", 32'(first_chan), 32'd0);
      check("dual first_code", 32'(first_code), 32'd3);
      check("dual first_ts",   32'(first_ts),   32'(saved_ts));

      // A later violation leaves the first-failure record alone.
      tick(1'b0, 1'b1);
      check("later err_pulse",  32'(err_pulse),  32'h2);
      check("later err_count",  32'(err_count),  32'd3);
      check("later first_chan", 32'(first_chan), 32'd0);
      check("later first_code", 32'(first_code), 32'd3);
      check("later first_ts",   32'(first_ts),   32'(saved_ts));

      // 300 more violations (2 per edge): 3 + 250 = 253 after 125 edges, then 255.
      for (int k = 1; k <= 150; k++) begin
         tick(1'b1, 1'b1);
         if (k == 125) check("sat pre count", 32'(err_count), 32'd253);
      end
      check("sat err_count",  32'(err_count),  32'd255);
      check("sat err_sticky", 32'(err_sticky), 32'h3);
      check("sat err_pulse",  32'(err_pulse),  32'h3);

      // clr together with a ch0 SPURIOUS_T: clear first, then record.
      if (c0 == 4'd15) tick(1'b0, 1'b0);
      clr = 1'b1;
      tick(1'b1, 1'b0);
      clr = 1'b0;
      saved_ts = edge_ts;
      check("clrhit err_count",   32'(err_count),   32'd1);
      check("clrhit err_sticky",  32'(err_sticky),  32'h1);
      check("clrhit first_valid", 32'(first_valid), 32'd1);
      check("clrhit first_chan",  32'(first_chan),  32'd0);
      check("clrhit first_code",  32'(first_code),  32'd2);
      check("clrhit first_ts",    32'(first_ts),    32'(saved_ts));

      // Drop en for one edge, resume with a count jump: no stale BAD_STEP.
      en = 1'b0;
      tick(1'b0, 1'b0);
      check("en low armed",     32'(armed),     32'd0);
      check("en low err_pulse", 32'(err_pulse), 32'd0);
      en = 1'b1;
      c0 = c0 + 4'd6;
      c1 = c1 + 4'd6;
      for (int k = 1; k <= 6; k++) begin
         tick(1'b0, 1'b0);
         check("rearm err_pulse", 32'(err_pulse), 32'd0);
         if (k == 2 || k == 3) check("rearm armed", 32'(armed), 32'(k == 3));
      end
      check("rearm err_count",  32'(err_count),  32'd1);
      check("rearm err_sticky", 32'(err_sticky), 32'h1);

      // Asynchronous reset mid-cycle clears everything without a clock edge.
      tick(1'b1, 1'b1);
      check("pre-reset err_pulse", 32'(err_pulse), 32'h3);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ts_model = '0;
      for (int k = 1; k <= 3; k++) begin
         tick(1'b0, 1'b0);
         check("post-reset armed", 32'(armed), 32'(k == 3));
      end
      exp_code = (c1 == 4'd15) ? 2'd1 : 2'd2;
      tick(1'b0, 1'b1);
      check("post-reset err_pulse",  32'(err_pulse),  32'h2);
      check("post-reset first_chan", 32'(first_chan), 32'd1);
      check("post-reset first_code", 32'(first_code), 32'(exp_code));
      check("post-reset first_ts",   32'(first_ts),   32'd3);
      check("post-reset err_count",  32'(err_count),  32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
